sd_audio_streamer: RTL and testbench
====================================

SD_AUDIO_STREAMER -- requirements
Module: sd_audio_streamer

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 512, meaning bytes per SD read block.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16384, meaning capacity of the downstream sample FIFO in bytes.
REQ-003 SHALL have parameter SAMPLE_PERIOD, default 3125, meaning clk cycles per audio sample (32 kHz at 100 MHz).
REQ-004 SHALL have one clock and an asynchronous active-low reset; all ports are synchronous to clk. The ports are:
- clk  in  1  100 MHz system clock.
- reset_n  in  1  async active-low reset.
- enable  in  1  level; 1 = stream, 0 = finish current block then idle.
- start_addr  in  32  first block byte address, 512-aligned.
- end_addr  in  32  exclusive end byte address, 512-aligned, > start_addr.
- sd_ready  in  1  sd_controller idle/ready.
- sd_byte_available  in  1  sd_controller new-byte strobe (level, may last several clk).
- sd_dout  in  8  sd_controller read byte.
- fifo_count  in  14  FIFO occupancy.
- fifo_full  in  1  FIFO full.
- fifo_empty  in  1  FIFO empty.
- sd_rd  out  1  read request to sd_controller.
- sd_adr  out  32  block address to sd_controller.
- fifo_wr_en  out  1  one-cycle FIFO write strobe.
- fifo_din  out  8  FIFO write data.
- fifo_rd_en  out  1  one-cycle FIFO read strobe at sample rate.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on reaching end_addr (no-loop build).
- underrun_count  out  16  saturating count of sample ticks with FIFO empty.

Function
REQ-005 SHALL implement states IDLE, WAIT_ROOM, REQUEST, RECEIVE, NEXT.
REQ-006 IDLE -> WAIT_ROOM when enable=1; sd_adr loaded with start_addr on that transition.
REQ-007 WAIT_ROOM -> REQUEST when sd_ready=1 and fifo_count <= FIFO_DEPTH-BLOCK_BYTES; if enable=0, return to IDLE instead.
REQ-008 REQUEST: sd_rd=1; hold until sd_ready=0 is sampled, then go to RECEIVE with sd_rd=0 on the following cycle.
REQ-009 RECEIVE: each rising edge of sd_byte_available (registered edge detect) SHALL produce fifo_wr_en=1 for exactly one cycle, one cycle after the edge, with fifo_din=sd_dout captured at the edge.
REQ-010 RECEIVE: the 10-bit byte counter increments per write; after the BLOCK_BYTES-th write go to NEXT.
REQ-011 Write attempted while fifo_full=1: the byte is dropped, with no wr_en and no stall; the counter still advances.
REQ-012 NEXT: sd_adr <= sd_adr+BLOCK_BYTES (32-bit). If the result equals end_addr, apply the wrap/stop rule (REQ-019). Otherwise go to WAIT_ROOM.
REQ-013 Sample tick: a free-running counter from 0 to SAMPLE_PERIOD-1 produces one tick per wrap; it runs in every state.
REQ-014 On a tick with fifo_empty=0: fifo_rd_en=1 for one cycle. With fifo_empty=1: fifo_rd_en=0 and underrun_count increments, saturating at 0xFFFF.
REQ-015 fifo_rd_en and fifo_wr_en in the same cycle SHALL be allowed; they are independent.
REQ-016 enable falling mid-block SHALL NOT abort the block; the block completes and NEXT goes to IDLE.

Reset
REQ-017 While reset_n=0, asynchronously: state=IDLE, sd_rd=0, sd_adr=0, fifo_wr_en=0, fifo_din=0, fifo_rd_en=0, done=0, underrun_count=0, byte and tick counters=0, edge register=0.
REQ-018 Reset mid-RECEIVE SHALL discard the partial block; after release, streaming restarts from start_addr.

Configuration
REQ-019 With SD_STREAM_LOOP_EN defined, sd_adr==end_addr in NEXT wraps to start_addr and streaming continues, with done never asserted. Without it, NEXT pulses done for one cycle and goes to IDLE; a new start requires enable to go 0 then 1.

Structure
REQ-020 Package sd_audio_pkg SHALL hold the state enum, BLOCK_BYTES, the default SAMPLE_PERIOD, and the address width constant.
REQ-021 Sub-module sample_tick_gen (parameter SAMPLE_PERIOD; outputs the tick) SHALL be instantiated once.

Verification
REQ-022 start=0, end=1024, enable=1, SD model with ready → 1024 writes with bytes matching the model, sd_adr sequence 0, 512; no-loop build: done pulse, IDLE.
REQ-023 fifo_count held at 15873 → no sd_rd; drop to 15872 → sd_rd within 2 cycles.
REQ-024 FIFO empty for 10 ticks → underrun_count=10, fifo_rd_en never high; tick spacing exactly 3125 cycles.
REQ-025 SD_STREAM_LOOP_EN, start=512, end=1536 → address sequence 512, 1024, 512, ... with no done.
REQ-026 reset_n low after 200 bytes of a block → all outputs at reset values immediately; after release, first sd_adr = start_addr.
REQ-027 sd_byte_available held high 4 cycles → exactly one fifo_wr_en.

Source files
------------

// File: rtl/sd_audio_pkg.sv
// Shared constants and FSM state type for the SD-card audio streamer.
package sd_audio_pkg;

    localparam int unsigned ADDR_W                = 32;
    localparam int unsigned SD_BLOCK_BYTES        = 512;
    localparam int unsigned SAMPLE_PERIOD_DEFAULT = 3125;
    localparam int unsigned BYTE_CNT_W            = 10;
    localparam int unsigned FIFO_CNT_W            = 14;
    localparam int unsigned UNDERRUN_W            = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROOM,
        REQUEST,
        RECEIVE,
        NEXT
    } state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running audio sample-rate tick: one registered pulse every SAMPLE_PERIOD clocks.
module sample_tick_gen
    import sd_audio_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = SAMPLE_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == CNT_W'(SAMPLE_PERIOD - 1));

    // Count 0..SAMPLE_PERIOD-1 and flag each wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= wrap ? '0 : cnt + CNT_W'(1);
            tick <= wrap;
        end
    end

endmodule

// File: rtl/sd_audio_streamer.sv
// Streams SD-card blocks into a sample FIFO and drains it at the audio rate.
// Build option: define SD_STREAM_LOOP_EN to wrap from end_addr back to
// start_addr forever; otherwise the stream stops with a done pulse.
module sd_audio_streamer
    import sd_audio_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES   = SD_BLOCK_BYTES,
    parameter int unsigned FIFO_DEPTH    = 16384,
    parameter int unsigned SAMPLE_PERIOD = SAMPLE_PERIOD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [ADDR_W-1:0]     end_addr,
    input  logic                  sd_ready,
    input  logic                  sd_byte_available,
    input  logic [7:0]            sd_dout,
    input  logic [FIFO_CNT_W-1:0] fifo_count,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  sd_rd,
    output logic [ADDR_W-1:0]     sd_adr,
    output logic                  fifo_wr_en,
    output logic [7:0]            fifo_din,
    output logic                  fifo_rd_en,
    output logic                  busy,
    output logic                  done,
    output logic [UNDERRUN_W-1:0] underrun_count
);

    localparam int unsigned ROOM_LIMIT = FIFO_DEPTH - BLOCK_BYTES;

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     adr_nxt, adr_inc;
    logic [BYTE_CNT_W-1:0] byte_cnt, byte_cnt_nxt;
    logic                  done_nxt;
    logic                  rearm_wait, rearm_wait_nxt;
    logic                  byte_avail_q;
    logic                  byte_edge;
    logic                  room_ok;
    logic                  tick;

    assign byte_edge = sd_byte_available & ~byte_avail_q;
    assign room_ok   = (32'(fifo_count) <= ROOM_LIMIT);
    assign adr_inc   = sd_adr + ADDR_W'(BLOCK_BYTES);

    sample_tick_gen #(
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Next-state and next-value logic for the block transfer FSM.
    always_comb begin
        state_nxt      = state;
        adr_nxt        = sd_adr;
        byte_cnt_nxt   = byte_cnt;
        done_nxt       = 1'b0;
        rearm_wait_nxt = rearm_wait & enable;
        case (state)
            IDLE: begin
                if (enable && !rearm_wait) begin
                    state_nxt = WAIT_ROOM;
                    adr_nxt   = start_addr;
                end
            end
            WAIT_ROOM: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (sd_ready && room_ok) begin
                    state_nxt = REQUEST;
                end
            end
            REQUEST: begin
                if (!sd_ready) begin
                    state_nxt = RECEIVE;
                end
            end
            RECEIVE: begin
                if (byte_edge) begin
                    if (byte_cnt == BYTE_CNT_W'(BLOCK_BYTES - 1)) begin
                        byte_cnt_nxt = '0;
                        state_nxt    = NEXT;
                    end else begin
                        byte_cnt_nxt = byte_cnt + BYTE_CNT_W'(1);
                    end
                end
            end
            NEXT: begin
                adr_nxt   = adr_inc;
                state_nxt = enable ? WAIT_ROOM : IDLE;
                if (adr_inc == end_addr) begin
`ifdef SD_STREAM_LOOP_EN
                    adr_nxt = start_addr;
`else
                    done_nxt       = 1'b1;
                    rearm_wait_nxt = 1'b1;
                    state_nxt      = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state and registered control outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sd_adr     <= '0;
            byte_cnt   <= '0;
            sd_rd      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rearm_wait <= 1'b0;
        end else begin
            state      <= state_nxt;
            sd_adr     <= adr_nxt;
            byte_cnt   <= byte_cnt_nxt;
            sd_rd      <= (state_nxt == REQUEST);
            busy       <= (state_nxt != IDLE);
            done       <= done_nxt;
            rearm_wait <= rearm_wait_nxt;
        end
    end

    // Byte strobe edge detect and FIFO write; bytes are dropped while the FIFO is full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_avail_q <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_din     <= '0;
        end else begin
            byte_avail_q <= sd_byte_available;
            fifo_wr_en   <= byte_edge && (state == RECEIVE) && !fifo_full;
            if (byte_edge && (state == RECEIVE)) begin
                fifo_din <= sd_dout;
            end
        end
    end

    // Sample-rate FIFO read and saturating underrun counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_rd_en     <= 1'b0;
            underrun_count <= '0;
        end else begin
            fifo_rd_en <= tick && !fifo_empty;
            if (tick && fifo_empty && (underrun_count != {UNDERRUN_W{1'b1}})) begin
                underrun_count <= underrun_count + UNDERRUN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sd_audio_streamer.sv
// Scoreboard bench for sd_audio_streamer: SD read model, FIFO-write scoreboard,
// room check, reset abort, end-of-stream behaviour and sample-rate underruns.
module tb_sd_audio_streamer;

    localparam int BB = 512;
    localparam int SP = 3125;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] start_addr = '0;
    logic [31:0] end_addr = '0;
    logic        sd_ready = 1'b1;
    logic        sd_byte_available = 1'b0;
    logic [7:0]  sd_dout = '0;
    logic [13:0] fifo_count = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_empty = 1'b0;
    logic        sd_rd;
    logic [31:0] sd_adr;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic        fifo_rd_en;
    logic        busy;
    logic        done;
    logic [15:0] underrun_count;

    int checks = 0;
    int passed = 0;
    int wr_seen = 0;
    int done_seen = 0;
    int rd_seen = 0;
    int sdrd_seen = 0;
    logic [7:0] exp_q[$];

    sd_audio_streamer #(
        .BLOCK_BYTES   (BB),
        .FIFO_DEPTH    (16384),
        .SAMPLE_PERIOD (SP)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .start_addr        (start_addr),
        .end_addr          (end_addr),
        .sd_ready          (sd_ready),
        .sd_byte_available (sd_byte_available),
        .sd_dout           (sd_dout),
        .fifo_count        (fifo_count),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .sd_rd             (sd_rd),
        .sd_adr            (sd_adr),
        .fifo_wr_en        (fifo_wr_en),
        .fifo_din          (fifo_din),
        .fifo_rd_en        (fifo_rd_en),
        .busy              (busy),
        .done              (done),
        .underrun_count    (underrun_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_byte(input logic [31:0] adr, input int idx);
        int v;
        v = int'(adr >> 9) * 29 + idx * 7 + 90;
        return v[7:0];
    endfunction

    // Output monitor: event counters and the FIFO-write scoreboard.
    always @(negedge clk) begin
        if (done) done_seen++;
        if (fifo_rd_en) rd_seen++;
        if (sd_rd) sdrd_seen++;
        if (fifo_wr_en) begin
            logic [7:0] exp_b;
            wr_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL wr_unexpected: got write din=%0h, required no write", fifo_din);
            end else begin
                exp_b = exp_q.pop_front();
                if (fifo_din !== exp_b)
                    $display("FAIL wr_data: got %0h, required %0h", fifo_din, exp_b);
                else
                    passed++;
            end
        end
    end

    // SD controller model: accept one request, then deliver bytes.
    task automatic serve_block(input logic [31:0] exp_adr, input int hold_cyc,
                               input int drop_lo, input int drop_hi,
                               input int disable_at, input int stop_after);
        int waited;
        logic [7:0] b;
        waited = 0;
        while (sd_rd !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (sd_rd !== 1'b1) begin
            $display("FAIL sd_rd_timeout: got sd_rd=%b, required 1 within 500 cycles", sd_rd);
            return;
        end
        passed++;
        checks++;
        if (sd_adr !== exp_adr)
            $display("FAIL sd_adr: got %0d, required %0d", sd_adr, exp_adr);
        else
            passed++;
        sd_ready = 1'b0;
        @(negedge clk);
        waited = 0;
        while (sd_rd === 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (sd_rd !== 1'b0)
            $display("FAIL sd_rd_release: got %b, required 0", sd_rd);
        else
            passed++;
        for (int i = 0; i < stop_after; i++) begin
            b = model_byte(exp_adr, i);
            sd_dout = b;
            sd_byte_available = 1'b1;
            fifo_full = (i >= drop_lo) && (i <= drop_hi);
            if (!fifo_full) exp_q.push_back(b);
            if (i == disable_at) enable = 1'b0;
            repeat (hold_cyc) @(negedge clk);
            sd_byte_available = 1'b0;
            fifo_full = 1'b0;
            @(negedge clk);
        end
        sd_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sd_rd !== 1'b0) $display("FAIL rst_sd_rd: got %b, required 0", sd_rd); else passed++;
        checks++; if (sd_adr !== 32'd0) $display("FAIL rst_sd_adr: got %0h, required 0", sd_adr); else passed++;
        checks++; if (fifo_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b, required 0", fifo_wr_en); else passed++;
        checks++; if (fifo_din !== 8'd0) $display("FAIL rst_din: got %0h, required 0", fifo_din); else passed++;
        checks++; if (fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b, required 0", fifo_rd_en); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b, required 0", done); else passed++;
        checks++; if (underrun_count !== 16'd0) $display("FAIL rst_underrun: got %0d, required 0", underrun_count); else passed++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        int w0, d0, s0, dis, exp_done;
`ifdef SD_STREAM_LOOP_EN
        dis = 300; exp_done = 0;
`else
        dis = -1;  exp_done = 1;
`endif
        start_addr = 32'd0; end_addr = 32'd1024;
        sd_ready = 1'b1; fifo_count = '0; fifo_empty = 1'b0;
        w0 = wr_seen; d0 = done_seen;
        enable = 1'b1;
        serve_block(32'd0, 2, -1, -1, -1, BB);
        serve_block(32'd512, 2, -1, -1, dis, BB);
        repeat (20) @(negedge clk);
        checks++; if (wr_seen - w0 !== 1024) $display("FAIL stream_writes: got %0d, required 1024", wr_seen - w0); else passed++;
        checks++; if (done_seen - d0 !== exp_done) $display("FAIL stream_done: got %0d pulses, required %0d", done_seen - d0, exp_done); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL stream_idle: got busy=%b, required 0", busy); else passed++;
        checks++; if (exp_q.size() != 0) $display("FAIL stream_pending: got %0d missing writes, required 0", exp_q.size()); else passed++;
        s0 = sdrd_seen;
        repeat (30) @(negedge clk);
        checks++; if (sdrd_seen - s0 !== 0) $display("FAIL stream_no_restart: got %0d sd_rd cycles, required 0", sdrd_seen - s0); else passed++;
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_room_drop_enable();
        int s0, w0, d0, n;
        start_addr = 32'd0; end_addr = 32'd1024;
        fifo_count = 14'd15873;
        enable = 1'b1;
        s0 = sdrd_seen;
        repeat (50) @(negedge clk);
        checks++; if (sdrd_seen - s0 !== 0) $display("FAIL room_blocked: got %0d sd_rd cycles, required 0", sdrd_seen - s0); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL room_busy: got %b, required 1", busy); else passed++;
        fifo_count = 14'd15872;
        n = 0;
        while (sd_rd !== 1'b1 && n < 2) begin
            @(negedge clk);
            n++;
        end
        checks++; if (sd_rd !== 1'b1) $display("FAIL room_release: got sd_rd=%b after %0d cycles, required 1 within 2", sd_rd, n); else passed++;
        w0 = wr_seen; d0 = done_seen;
        serve_block(32'd0, 4, 10, 19, 100, BB);
        repeat (10) @(negedge clk);
        checks++; if (wr_seen - w0 !== 502) $display("FAIL drop_writes: got %0d, required 502", wr_seen - w0); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL enable_fall_idle: got busy=%b, required 0", busy); else passed++;
        checks++; if (sd_adr !== 32'd512) $display("FAIL enable_fall_adr: got %0d, required 512", sd_adr); else passed++;
        checks++; if (done_seen - d0 !== 0) $display("FAIL enable_fall_done: got %0d pulses, required 0", done_seen - d0); else passed++;
        checks++; if (exp_q.size() != 0) $display("FAIL drop_pending: got %0d missing writes, required 0", exp_q.size()); else passed++;
        fifo_count = '0;
    endtask

    task automatic test_reset_mid_block();
        start_addr = 32'd0; end_addr = 32'd1024;
        enable = 1'b1;
        serve_block(32'd0, 2, -1, -1, -1, 200);
        reset_n = 1'b0;
        #1;
        checks++; if (sd_rd !== 1'b0) $display("FAIL midrst_sd_rd: got %b, required 0", sd_rd); else passed++;
        checks++; if (sd_adr !== 32'd0) $display("FAIL midrst_sd_adr: got %0d, required 0", sd_adr); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b, required 0", busy); else passed++;
        checks++; if (fifo_wr_en !== 1'b0) $display("FAIL midrst_wr_en: got %b, required 0", fifo_wr_en); else passed++;
        checks++; if (fifo_din !== 8'd0) $display("FAIL midrst_din: got %0h, required 0", fifo_din); else passed++;
        exp_q.delete();
        start_addr = 32'd512; end_addr = 32'd1536;
        sd_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_end_of_stream();
        int d0, w0;
        d0 = done_seen; w0 = wr_seen;
        serve_block(32'd512, 2, -1, -1, -1, BB);
        serve_block(32'd1024, 2, -1, -1, -1, BB);
`ifdef SD_STREAM_LOOP_EN
        serve_block(32'd512, 2, -1, -1, 50, BB);
        repeat (20) @(negedge clk);
        checks++; if (done_seen - d0 !== 0) $display("FAIL loop_done: got %0d pulses, required 0", done_seen - d0); else passed++;
        checks++; if (sd_adr !== 32'd1024) $display("FAIL loop_adr: got %0d, required 1024", sd_adr); else passed++;
        checks++; if (wr_seen - w0 !== 3 * BB) $display("FAIL loop_writes: got %0d, required %0d", wr_seen - w0, 3 * BB); else passed++;
`else
        repeat (20) @(negedge clk);
        checks++; if (done_seen - d0 !== 1) $display("FAIL stop_done: got %0d pulses, required 1", done_seen - d0); else passed++;
        checks++; if (sd_adr !== 32'd1536) $display("FAIL stop_adr: got %0d, required 1536", sd_adr); else passed++;
        checks++; if (wr_seen - w0 !== 2 * BB) $display("FAIL stop_writes: got %0d, required %0d", wr_seen - w0, 2 * BB); else passed++;
`endif
        checks++; if (busy !== 1'b0) $display("FAIL end_idle: got busy=%b, required 0", busy); else passed++;
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_underrun();
        int r0, n, incs, cyc;
        int stamp[10];
        logic [15:0] prev;
        fifo_empty = 1'b0;
        r0 = rd_seen; n = 0;
        while (rd_seen == r0 && n < SP + 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rd_seen == r0) $display("FAIL rd_en_tick: got no fifo_rd_en in %0d cycles, required one", n); else passed++;
        checks++; if (underrun_count !== 16'd0) $display("FAIL underrun_start: got %0d, required 0", underrun_count); else passed++;
        fifo_empty = 1'b1;
        @(negedge clk);
        r0 = rd_seen;
        prev = underrun_count;
        incs = 0; cyc = 0;
        while (incs < 10 && cyc < 11 * SP) begin
            @(negedge clk);
            cyc++;
            if (underrun_count !== prev) begin
                stamp[incs] = cyc;
                incs++;
                prev = underrun_count;
            end
        end
        checks++; if (incs != 10) $display("FAIL underrun_ticks: got %0d increments, required 10", incs); else passed++;
        checks++; if (underrun_count !== 16'd10) $display("FAIL underrun_count: got %0d, required 10", underrun_count); else passed++;
        checks++; if (rd_seen != r0) $display("FAIL underrun_rd_en: got %0d reads, required 0", rd_seen - r0); else passed++;
        for (int i = 1; i < incs; i++) begin
            checks++;
            if (stamp[i] - stamp[i-1] != SP)
                $display("FAIL tick_spacing: got %0d cycles, required %0d", stamp[i] - stamp[i-1], SP);
            else
                passed++;
        end
        fifo_empty = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_room_drop_enable();
        test_reset_mid_block();
        test_end_of_stream();
        test_underrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
